// File: rtl/des_key_pkg.sv
// Shared DES key-schedule definitions: round count, forward/reverse rotation
// schedules, the PC-2 selection table, the schedule FSM states and small
// rotation helpers.
// Bit numbering matches DES: bit 1 of a 28-bit half sits at index [28] (MSB).
package des_key_pkg;

    localparam int ROUNDS = 16;

    // Reverse (decrypt) per-round right-rotation amounts, rounds 1..16
    localparam int SHIFT_R [1:16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Forward (encrypt) per-round left-rotation amounts, rounds 1..16
    localparam int SHIFT_L [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // PC-2: output bit j (DES numbering) takes input bit PC2[j] of the 56-bit {C,D}
    localparam int PC2 [1:48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_e;

    // Right-rotation amount applied when moving into the given decrypt round
    function automatic logic [1:0] shift_r_at(input logic [4:0] round);
        shift_r_at = 2'd0;
        for (int i = 1; i <= ROUNDS; i++) begin
            if (5'(i) == round) begin
                shift_r_at = 2'(SHIFT_R[i]);
            end
        end
    endfunction

    // Right-rotate a 28-bit half by 0, 1 or 2 positions
    function automatic logic [28:1] rotr(input logic [28:1] x, input logic [1:0] n);
        case (n)
            2'd1:    rotr = {x[1], x[28:2]};
            2'd2:    rotr = {x[2:1], x[28:3]};
            default: rotr = x;
        endcase
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational DES PC-2: selects 48 of the 56 {C,D} bits to form a round subkey.
// Only compiled when RIGHT_SHIFT_PC2_EN is defined; without it the key-schedule
// has no on-chip PC-2 and this module would be an orphan.
`ifdef RIGHT_SHIFT_PC2_EN
module des_pc2
    import des_key_pkg::*;
(
    input  logic [56:1] cd,
    output logic [48:1] subkey
);

    // Pure wiring: DES bit k lives at index (57-k) of cd and (49-k) of subkey
    for (genvar j = 1; j <= 48; j++) begin : g_bit
        assign subkey[49-j] = cd[57-PC2[j]];
    end

endmodule
`endif

// File: rtl/right_shift_key_schedule.sv
// Decrypt-side DES key schedule: latches the PC-1 C/D halves on a start pulse
// and emits the 16 round-key halves in reverse order, one per clock.
// Optional: RIGHT_SHIFT_PC2_EN adds a registered PC-2 subkey output aligned
// with Right_Shift_Valid.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for Right_Shift_Start; outputs hold last C/D, flags 0
// RUN   | emitting rounds 1..16, Round holds the current index
module right_shift_key_schedule
    import des_key_pkg::*;
#(
    parameter int ROUNDS = des_key_pkg::ROUNDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Right_Shift_Start,
    input  logic [28:1] Right_Shift_Left_Input,
    input  logic [28:1] Right_Shift_Right_Input,
    output logic [28:1] Right_Shift_Left_Output,
    output logic [28:1] Right_Shift_Right_Output,
    output logic [4:0]  Right_Shift_Round,
    output logic        Right_Shift_Valid,
    output logic        Right_Shift_Busy,
    output logic        Right_Shift_Finish_Flag
`ifdef RIGHT_SHIFT_PC2_EN
    ,
    output logic [48:1] Right_Shift_Subkey
`endif
);

    ks_state_e   state_q, state_d;
    logic [4:0]  round_q, round_d;
    logic [28:1] c_q, c_d;
    logic [28:1] d_q, d_d;
    logic        last_round;

    assign last_round = (round_q == 5'(ROUNDS));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Right_Shift_Start) state_d = RUN;
            RUN:     if (last_round)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load unrotated on start, then rotate into each round
    always_comb begin
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (Right_Shift_Start) begin
                    c_d     = Right_Shift_Left_Input;
                    d_d     = Right_Shift_Right_Input;
                    round_d = 5'd1;
                end
            end
            RUN: begin
                if (last_round) begin
                    round_d = 5'd0;
                end else begin
                    round_d = round_q + 5'd1;
                    c_d     = rotr(c_q, shift_r_at(round_q + 5'd1));
                    d_d     = rotr(d_q, shift_r_at(round_q + 5'd1));
                end
            end
            default: round_d = 5'd0;
        endcase
    end

    // Datapath registers; C/D keep their last value after the final round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
        end else begin
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
        end
    end

    // Outputs decoded from registered state so they clear with reset at once
    always_comb begin
        Right_Shift_Left_Output  = c_q;
        Right_Shift_Right_Output = d_q;
        Right_Shift_Round        = round_q;
        Right_Shift_Valid        = (state_q == RUN);
        Right_Shift_Busy         = (state_q == RUN);
        Right_Shift_Finish_Flag  = (state_q == RUN) && last_round;
    end

`ifdef RIGHT_SHIFT_PC2_EN
    logic [48:1] subkey_d;
    logic [48:1] subkey_q;

    des_pc2 u_pc2 (
        .cd     ({c_d, d_d}),
        .subkey (subkey_d)
    );

    // Subkey is taken from the next C/D so it lands in the same cycle as them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            subkey_q <= '0;
        end else begin
            subkey_q <= subkey_d;
        end
    end

    assign Right_Shift_Subkey = subkey_q;
`endif

endmodule
